dsp_mac_sequencer: RTL and testbench

- Command-driven controller sitting in front of one DSP48A1-style slice configured with all pipeline registers on (A0/A1/B0/B1/C/D/M/P/OPMODE/CARRYIN regs = 1, CARRYINSEL = "OPMODE5", B_INPUT = "DIRECT").
- Accepts multiply-type commands over a valid/ready handshake and drives the slice's operand, OPMODE, CE and reset pins.
- Tracks in-flight operations and returns P results with a valid strobe.
- Guarantees OPMODE never changes while data is in the slice pipeline, and clears the accumulator at the start of every MACC burst.

---
 rtl/dsp_seq_pkg.sv | 38 +++
 rtl/dsp_mac_sequencer_if.sv | 27 ++
 rtl/dsp_seq_valid_pipe.sv | 35 +++
 rtl/dsp_mac_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP48A1 MAC sequencer: operation codes,
// slice OPMODE words, FSM states and the default slice latency.
package dsp_seq_pkg;

    typedef enum logic [1:0] {
        OpMul    = 2'b00,
        OpPremul = 2'b01,
        OpMacc   = 2'b10,
        OpMuladd = 2'b11
    } op_e;

    // OPMODE: bit7 post-sub, bit6 pre-sub, bit5 carryin, bit4 pre-add, 3:2 Z, 1:0 X
    localparam logic [7:0] OpmodeMul    = 8'b0000_0001;
    localparam logic [7:0] OpmodePremul = 8'b0001_0001;
    localparam logic [7:0] OpmodeMacc   = 8'b0000_1001;
    localparam logic [7:0] OpmodeMuladd = 8'b0000_1101;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StRun,
        StDrain
    } state_e;

    localparam int unsigned DefaultLat = 4;

    function automatic logic [7:0] opmode_of(op_e op);
        logic [7:0] opm;
        unique case (op)
            OpMul:    opm = OpmodeMul;
            OpPremul: opm = OpmodePremul;
            OpMacc:   opm = OpmodeMacc;
            OpMuladd: opm = OpmodeMuladd;
        endcase
        return opm;
    endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Command and result bundle of the MAC sequencer; master issues commands,
// slave (the sequencer) accepts them and returns results without backpressure.
interface dsp_mac_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        cmd_last;
    logic [17:0] cmd_a;
    logic [17:0] cmd_b;
    logic [17:0] cmd_d;
    logic [47:0] cmd_c;
    logic        res_valid;
    logic [47:0] res_p;
    logic        res_carry;

    modport master (
        output cmd_valid, cmd_op, cmd_last, cmd_a, cmd_b, cmd_d, cmd_c,
        input  cmd_ready, res_valid, res_p, res_carry
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_last, cmd_a, cmd_b, cmd_d, cmd_c,
        output cmd_ready, res_valid, res_p, res_carry
    );

endinterface

// File: rtl/dsp_seq_valid_pipe.sv
// Token shift register aligned with the slice pipeline. Tracks result-bearing
// tokens and, separately, every accepted element for in-flight accounting.
module dsp_seq_valid_pipe #(
    parameter int unsigned Depth = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic token_i,
    output logic tok_exit_o,
    output logic elem_exit_o
);

    logic [Depth-1:0] tok_q, tok_d;
    logic [Depth-1:0] elem_q, elem_d;

    always_comb begin
        tok_d  = {tok_q[Depth-2:0], push_i & token_i};
        elem_d = {elem_q[Depth-2:0], push_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tok_q  <= '0;
            elem_q <= '0;
        end else begin
            tok_q  <= tok_d;
            elem_q <= elem_d;
        end
    end

    assign tok_exit_o  = tok_q[Depth-1];
    assign elem_exit_o = elem_q[Depth-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Command sequencer for one fully pipelined DSP48A1 slice. Optional performance
// counters (perf_ops, perf_stall) are built when SEQ_PERF_CNT_EN is defined.
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int unsigned LAT = DefaultLat,
    parameter int unsigned CW  = 3
) (
    input  logic               CLK,
    input  logic               RSTN,
    dsp_mac_sequencer_if.slave bus,
    output logic               busy,
    output logic [17:0]        dsp_a,
    output logic [17:0]        dsp_b,
    output logic [17:0]        dsp_d,
    output logic [47:0]        dsp_c,
    output logic [7:0]         dsp_opmode,
    output logic               dsp_carryin,
    output logic               dsp_ce,
    output logic               dsp_rst_pm,
    output logic               dsp_rst_all,
    input  logic [47:0]        dsp_p,
    input  logic               dsp_carryout
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]        perf_ops,
    output logic [31:0]        perf_stall
`endif
);

    state_e        state_q, state_d;
    op_e           cur_op_q, cur_op_d;
    logic          macc_done_q, macc_done_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [17:0]   dsp_a_q, dsp_a_d;
    logic [17:0]   dsp_b_q, dsp_b_d;
    logic [17:0]   dsp_d_q, dsp_d_d;
    logic [47:0]   dsp_c_q, dsp_c_d;
    logic [7:0]    dsp_opmode_q, dsp_opmode_d;
    logic          dsp_ce_q, dsp_ce_d;
    logic          dsp_rst_pm_q, dsp_rst_pm_d;
    logic          dsp_rst_all_q, dsp_rst_all_d;
    logic          res_valid_q, res_valid_d;
    logic [47:0]   res_p_q, res_p_d;
    logic          res_carry_q, res_carry_d;

    op_e  cmd_op;
    logic accept;
    logic token;
    logic tok_exit;
    logic elem_exit;
    logic start_setup;

    assign cmd_op = op_e'(bus.cmd_op);
    assign accept = (state_q == StRun) && bus.cmd_valid && (cmd_op == cur_op_q) && !macc_done_q;
    // MACC partial sums are never reported; only the closing element yields a result.
    assign token  = (cur_op_q != OpMacc) || bus.cmd_last;

    dsp_seq_valid_pipe #(
        .Depth (LAT + 1)
    ) u_valid_pipe (
        .clk_i       (CLK),
        .rst_ni      (RSTN),
        .push_i      (accept),
        .token_i     (token),
        .tok_exit_o  (tok_exit),
        .elem_exit_o (elem_exit)
    );

    always_comb begin
        state_d       = state_q;
        cur_op_d      = cur_op_q;
        macc_done_d   = macc_done_q;
        inflight_d    = inflight_q + CW'(accept) - CW'(elem_exit);
        dsp_a_d       = '0;
        dsp_b_d       = '0;
        dsp_d_d       = '0;
        dsp_c_d       = '0;
        dsp_opmode_d  = dsp_opmode_q;
        dsp_ce_d      = dsp_ce_q;
        dsp_rst_pm_d  = 1'b0;
        dsp_rst_all_d = 1'b0;
        res_valid_d   = tok_exit;
        res_p_d       = tok_exit ? dsp_p : res_p_q;
        res_carry_d   = tok_exit ? dsp_carryout : res_carry_q;
        start_setup   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    start_setup = 1'b1;
                end
            end
            StSetup: begin
                state_d = StRun;
            end
            StRun: begin
                if (accept) begin
                    dsp_a_d = bus.cmd_a;
                    dsp_b_d = bus.cmd_b;
                    dsp_d_d = bus.cmd_d;
                    dsp_c_d = bus.cmd_c;
                    if (cur_op_q == OpMacc && bus.cmd_last) begin
                        macc_done_d = 1'b1;
                    end
                end
                if (macc_done_q || (bus.cmd_valid && cmd_op != cur_op_q)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // OPMODE may only move once the slice pipeline is empty.
                if (inflight_q == '0) begin
                    macc_done_d = 1'b0;
                    if (bus.cmd_valid) begin
                        start_setup = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
        endcase

        if (start_setup) begin
            state_d      = StSetup;
            cur_op_d     = cmd_op;
            dsp_opmode_d = opmode_of(cmd_op);
            dsp_ce_d     = 1'b1;
            // Clearing M and P here starts every MACC burst from zero.
            dsp_rst_pm_d = (cmd_op == OpMacc);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q       <= StIdle;
            cur_op_q      <= OpMul;
            macc_done_q   <= 1'b0;
            inflight_q    <= '0;
            dsp_a_q       <= '0;
            dsp_b_q       <= '0;
            dsp_d_q       <= '0;
            dsp_c_q       <= '0;
            dsp_opmode_q  <= '0;
            dsp_ce_q      <= 1'b0;
            dsp_rst_pm_q  <= 1'b1;
            dsp_rst_all_q <= 1'b1;
            res_valid_q   <= 1'b0;
            res_p_q       <= '0;
            res_carry_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_op_q      <= cur_op_d;
            macc_done_q   <= macc_done_d;
            inflight_q    <= inflight_d;
            dsp_a_q       <= dsp_a_d;
            dsp_b_q       <= dsp_b_d;
            dsp_d_q       <= dsp_d_d;
            dsp_c_q       <= dsp_c_d;
            dsp_opmode_q  <= dsp_opmode_d;
            dsp_ce_q      <= dsp_ce_d;
            dsp_rst_pm_q  <= dsp_rst_pm_d;
            dsp_rst_all_q <= dsp_rst_all_d;
            res_valid_q   <= res_valid_d;
            res_p_q       <= res_p_d;
            res_carry_q   <= res_carry_d;
        end
    end

    assign bus.cmd_ready = accept;
    assign bus.res_valid = res_valid_q;
    assign bus.res_p     = res_p_q;
    assign bus.res_carry = res_carry_q;

    assign busy        = (inflight_q != '0) || (state_q != StRun);
    assign dsp_a       = dsp_a_q;
    assign dsp_b       = dsp_b_q;
    assign dsp_d       = dsp_d_q;
    assign dsp_c       = dsp_c_q;
    assign dsp_opmode  = dsp_opmode_q;
    assign dsp_carryin = 1'b0;
    assign dsp_ce      = dsp_ce_q;
    assign dsp_rst_pm  = dsp_rst_pm_q;
    assign dsp_rst_all = dsp_rst_all_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (accept && perf_ops_q != '1) begin
            perf_ops_d = perf_ops_q + 32'd1;
        end
        if ((state_q == StSetup || state_q == StDrain) && perf_stall_q != '1) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Scoreboard bench for dsp_mac_sequencer driving a behavioural model of a
// fully pipelined DSP48A1 slice (A0/A1, B0/B1 with pre-adder, M, P).
module tb_dsp_mac_sequencer;
    import dsp_seq_pkg::*;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    dsp_mac_sequencer_if bus ();

    logic        busy;
    logic [17:0] dsp_a, dsp_b, dsp_d;
    logic [47:0] dsp_c;
    logic [7:0]  dsp_opmode;
    logic        dsp_carryin, dsp_ce, dsp_rst_pm, dsp_rst_all;
    logic [47:0] dsp_p;
    logic        dsp_carryout;

    dsp_mac_sequencer #(
        .LAT (4),
        .CW  (3)
    ) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .bus          (bus),
        .busy         (busy),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_d        (dsp_d),
        .dsp_c        (dsp_c),
        .dsp_opmode   (dsp_opmode),
        .dsp_carryin  (dsp_carryin),
        .dsp_ce       (dsp_ce),
        .dsp_rst_pm   (dsp_rst_pm),
        .dsp_rst_all  (dsp_rst_all),
        .dsp_p        (dsp_p),
        .dsp_carryout (dsp_carryout)
    );

    // Slice model; C is delayed to line up with the product at the P stage.
    logic signed [17:0] a0_r, a1_r, b0_r, b1_r, d0_r;
    logic        [47:0] c0_r, c1_r, c2_r, p_r;
    logic signed [35:0] m_r;
    logic        [7:0]  opm_r;
    logic               co_r;
    logic        [47:0] x_mux, z_mux;

    always_comb begin
        x_mux = (opm_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0;
        case (opm_r[3:2])
            2'b10:   z_mux = p_r;
            2'b11:   z_mux = c2_r;
            default: z_mux = 48'd0;
        endcase
    end

    always @(posedge CLK) begin
        if (dsp_rst_all) begin
            a0_r <= '0; a1_r <= '0; b0_r <= '0; b1_r <= '0; d0_r <= '0;
            c0_r <= '0; c1_r <= '0; c2_r <= '0; opm_r <= '0;
            m_r <= '0; p_r <= '0; co_r <= 1'b0;
        end else if (dsp_ce) begin
            a0_r  <= dsp_a;
            a1_r  <= a0_r;
            b0_r  <= dsp_b;
            d0_r  <= dsp_d;
            opm_r <= dsp_opmode;
            b1_r  <= opm_r[4] ? (opm_r[6] ? d0_r - b0_r : d0_r + b0_r) : b0_r;
            c0_r  <= dsp_c;
            c1_r  <= c0_r;
            c2_r  <= c1_r;
            if (dsp_rst_pm) begin
                m_r  <= '0;
                p_r  <= '0;
                co_r <= 1'b0;
            end else begin
                m_r         <= a1_r * b1_r;
                {co_r, p_r} <= {1'b0, x_mux} + {1'b0, z_mux};
            end
        end
    end

    assign dsp_p        = p_r;
    assign dsp_carryout = co_r;

    typedef struct {
        logic [47:0] p;
        logic [7:0]  opm;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   res_pulses = 0;
    int   rstpm_cnt = 0;
    int   last_acc = -100;
    logic [7:0] prev_opm = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: pops the scoreboard on every result strobe.
    initial forever begin
        @(negedge CLK);
        if (RSTN) begin
            if (bus.res_valid) begin
                res_pulses++;
                if (sb.size() == 0) begin
                    check("unexpected res_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("res_p/res_carry", {bus.res_carry, bus.res_p}, {1'b0, e.p});
                    check("res latency", cyc - e.acc, 6);
                    check("opmode at result", dsp_opmode, e.opm);
                end
            end
            if (dsp_rst_pm && !dsp_rst_all) rstpm_cnt++;
            if (dsp_opmode != prev_opm) check("opmode moved in flight", (cyc - last_acc) >= 6, 1);
            prev_opm = dsp_opmode;
        end else begin
            prev_opm = dsp_opmode;
            last_acc = -100;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [17:0] a, input logic [17:0] b,
                         input logic [17:0] d, input logic [47:0] c, input logic last,
                         input logic expv, input logic [47:0] expp, input logic [7:0] opm,
                         output int waited);
        int  start;
        bit  done;
        done          = 0;
        waited        = -1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_d     = d;
        bus.cmd_c     = c;
        bus.cmd_last  = last;
        start         = cyc;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            if (bus.cmd_ready) begin
                done     = 1;
                waited   = cyc - start;
                last_acc = cyc;
                if (expv) sb.push_back('{p: expp, opm: opm, acc: cyc});
            end
            @(posedge CLK);
            #1;
        end
        if (!done) check("accept timeout", 0, 1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge CLK);
        repeat (2) @(posedge CLK);
        #1;
        check("scoreboard drained", sb.size(), 0);
    endtask

    initial begin
        int w;
        int pulses_before;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_last  = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_d     = '0;
        bus.cmd_c     = '0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset ctrl", {bus.cmd_ready, bus.res_valid, dsp_ce, dsp_rst_all, dsp_rst_pm, busy,
                             dsp_opmode}, {6'b000111, 8'h00});
        check("reset data", {dsp_a, dsp_b, dsp_d, dsp_c}, 0);
        check("reset res_p", {bus.res_carry, bus.res_p}, 0);
        @(posedge CLK);
        #1 RSTN = 1'b1;
        @(negedge CLK);
        check("rst_all before first edge", dsp_rst_all, 1);
        @(posedge CLK);
        #1;
        check("slice resets dropped", {dsp_rst_all, dsp_rst_pm}, 0);

        issue(OpMul, 3, 10, 0, 0, 0, 1, 48'd30, OpmodeMul, w);
        check("idle-setup-run wait", w, 2);
        issue(OpPremul, 3, 10, 9, 0, 0, 1, 48'd57, OpmodePremul, w);

        rstpm_cnt = 0;
        issue(OpMacc, 2, 3, 0, 0, 0, 0, 48'd0, OpmodeMacc, w);
        issue(OpMacc, 4, 5, 0, 0, 0, 0, 48'd0, OpmodeMacc, w);
        check("macc back-to-back", w, 0);
        issue(OpMacc, 6, 7, 0, 0, 1, 1, 48'd68, OpmodeMacc, w);
        issue(OpMacc, 1, 1, 0, 0, 1, 1, 48'd1, OpmodeMacc, w);
        check("rst_pm pulses per burst", rstpm_cnt, 2);

        issue(OpMul, 2, 5, 0, 0, 0, 1, 48'd10, OpmodeMul, w);
        issue(OpMuladd, 2, 5, 0, 48'd100, 0, 1, 48'd110, OpmodeMuladd, w);
        check("drain then setup wait", w, 7);

        issue(OpMul, 1, 1, 0, 0, 0, 1, 48'd1, OpmodeMul, w);
        issue(OpMul, 2, 2, 0, 0, 0, 1, 48'd4, OpmodeMul, w);
        check("mul 2x2 back-to-back", w, 0);
        issue(OpMul, 3, 3, 0, 0, 0, 1, 48'd9, OpmodeMul, w);
        check("mul 3x3 back-to-back", w, 0);
        issue(OpMul, 4, 4, 0, 0, 0, 1, 48'd16, OpmodeMul, w);
        check("mul 4x4 back-to-back", w, 0);
        wait_empty();

        pulses_before = res_pulses;
        issue(OpMul, 5, 5, 0, 0, 0, 0, 48'd0, OpmodeMul, w);
        repeat (2) @(posedge CLK);
        #1 RSTN = 1'b0;
        @(negedge CLK);
        check("mid reset ctrl", {bus.cmd_ready, bus.res_valid, dsp_ce, dsp_rst_all, dsp_rst_pm, busy,
                                 dsp_opmode}, {6'b000111, 8'h00});
        check("mid reset data", {dsp_a, dsp_b, dsp_d, dsp_c}, 0);
        repeat (2) @(posedge CLK);
        #1 RSTN = 1'b1;
        repeat (12) @(posedge CLK);
        #1;
        check("no result after reset", res_pulses - pulses_before, 0);

        issue(OpMul, 7, 7, 0, 0, 0, 1, 48'd49, OpmodeMul, w);
        check("post-reset setup wait", w, 2);
        wait_empty();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
